sram_result_reader: RTL and testbench

//  Read-side sequencer for the result SRAM. After the ALU/write-back pass finishes, it

---
 rtl/sram_result_reader.sv | 158 +++++++++++++++
 tb/tb_sram_result_reader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_result_reader.sv
// Result SRAM read sequencer: walks addresses 0..NUM_WORDS-1 over the
// read_n/ry port and streams each word to the host on valid/ready.
module sram_result_reader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 9,
  parameter int NUM_WORDS = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              read_n,
  output logic [ADDR_W-1:0] r_addr,
  input  logic              ry,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(NUM_WORDS - 1);

  localparam logic [CNT_W-1:0] TO_MAX =
    CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_inc;

  logic              read_n_d;
  logic [ADDR_W-1:0] r_addr_d;
  logic              out_valid_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_last_d;
  logic              busy_d;
  logic              done_d;
  logic              err_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    r_addr_d    = r_addr;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    err_d       = err;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end

      REQ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end

      WAIT: begin
        if (ry) begin
          state_d     = HOLD;
          out_data_d  = data_in;
          out_valid_d = 1'b1;
          out_last_d  = (addr_q == LAST_ADDR);
        end else if (cnt_inc == TO_MAX) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            addr_d  = addr_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobe and address are registered from the next state
    read_n_d = (state_d != REQ);
    if (state_d == REQ) begin
      r_addr_d = addr_d;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      read_n    <= 1'b1;
      r_addr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      read_n    <= read_n_d;
      r_addr    <= r_addr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_result_reader.sv
// Bench for sram_result_reader: SRAM responder, host sink and a
// word-order scoreboard checked every cycle, plus directed timing pins.
module tb_sram_result_reader;

  localparam int NUM = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       read_n;
  logic [4:0] r_addr;
  logic       ry;
  logic [8:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;

  logic       start_m = 1'b0;
  logic       start_i = 1'b0;
  logic       ry_r = 1'b0;
  logic       ry_i = 1'b0;
  logic [8:0] data_r = '0;

  assign start   = start_m | start_i;
  assign ry      = ry_r | ry_i;
  assign data_in = ry_i ? 9'h0AA : data_r;

  sram_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .read_n    (read_n),
    .r_addr    (r_addr),
    .ry        (ry),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [8:0] mem [32];

  int ry_delay = 0;
  int never_addr = -1;
  int ready_default = 1;
  int stall_word = 0;
  int stall_len = 0;
  int stalled = 0;
  int inj_en = 0;

  int exp_addr = 0;
  int exp_word = 0;
  int rd_pulses = 0;
  int last_cnt = 0;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM model: answers a read strobe ry_delay cycles into WAIT
  initial begin : responder
    int busyreq;
    int age;
    int a;
    busyreq = 0;
    age = 0;
    a = 0;
    forever begin
      @(negedge clk);
      ry_r = 1'b0;
      if (busyreq != 0) begin
        if (age == ry_delay && a != never_addr) begin
          ry_r = 1'b1;
          data_r = mem[a];
          busyreq = 0;
        end else begin
          age++;
        end
      end
      if (!read_n) begin
        busyreq = 1;
        age = 0;
        a = int'(r_addr);
      end
    end
  end

  // Host sink with optional stall on one word
  initial forever begin
    @(posedge clk);
    #1;
    if (!busy) stalled = 0;
    if (stall_len > 0 && out_valid && exp_word == stall_word
        && stalled < stall_len) begin
      out_ready = 1'b0;
      stalled++;
    end else begin
      out_ready = (ready_default != 0);
    end
  end

  // Stray start and ry in the middle of a stalled HOLD
  initial forever begin
    @(posedge clk);
    #2;
    start_i = (inj_en != 0) && out_valid && !out_ready
              && stalled == 2;
    ry_i = start_i;
  end

  // Scoreboard: addresses issued in order, words delivered in order
  initial begin : monitor
    logic       pv;
    logic       pacc;
    logic [8:0] pd;
    logic       pl;
    pv = 1'b0;
    pacc = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (start && !busy) begin
          exp_addr = 0;
          exp_word = 0;
        end
        if (!read_n) begin
          check("rd_addr", int'(r_addr), exp_addr);
          check("rd_in_hold", int'(out_valid), 0);
          exp_addr++;
          rd_pulses++;
        end
        if (out_valid && pv && !pacc) begin
          check("hold_data", int'(out_data), int'(pd));
          check("hold_last", int'(out_last), int'(pl));
        end
        if (out_valid && !out_ready) begin
          check("stall_rn", int'(read_n), 1);
          check("stall_addr", int'(r_addr), exp_word);
        end
        if (!out_valid) begin
          check("last_idle", int'(out_last), 0);
        end else if (out_ready) begin
          check("word", int'(out_data),
                (exp_word < NUM) ? int'(mem[exp_word]) : -1);
          check("last", int'(out_last),
                (exp_word == NUM - 1) ? 1 : 0);
          if (out_last) last_cnt++;
          exp_word++;
        end
      end
      pv = out_valid;
      pacc = out_valid && out_ready;
      pd = out_data;
      pl = out_last;
    end
  end

  task automatic run_pass(input int exp_len, input string nm,
                          input int start_in_done);
    int t;
    int n;
    int dc;
    @(posedge clk);
    #1;
    start_m = 1'b1;
    @(posedge clk);
    #1;
    t = cyc;
    start_m = 1'b0;
    check({nm, "_rn0"}, int'(read_n), 0);
    check({nm, "_busy"}, int'(busy), 1);
    check({nm, "_errclr"}, int'(err), 0);
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    dc = cyc + 1;
    check({nm, "_donewait"}, int'(done), 1);
    check({nm, "_len"}, dc - t, exp_len);
    if (start_in_done != 0) begin
      start_m = 1'b1;
      @(posedge clk);
      #1;
      start_m = 1'b0;
      check("done_start_busy", int'(busy), 0);
      check("done_start_rn", int'(read_n), 1);
      @(posedge clk);
      #1;
      check("done_start_idle", int'(busy), 0);
    end
  endtask

  initial begin : main
    int p0;
    int l0;
    int n;
    for (int k = 0; k < 32; k++) mem[k] = 9'(9'h100 + k);
    rst = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rn", int'(read_n), 1);
    check("rst_addr", int'(r_addr), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b1;

    // full pass at 3 cycles per word
    p0 = rd_pulses;
    l0 = last_cnt;
    run_pass(49, "t2", 1);
    check("t2_pulses", rd_pulses - p0, 16);
    check("t2_lastcnt", last_cnt - l0, 1);
    check("t2_words", exp_word, 16);
    check("t2_err", int'(err), 0);

    // backpressure on word 3
    stall_word = 3;
    stall_len = 5;
    p0 = rd_pulses;
    run_pass(54, "t3", 0);
    stall_len = 0;
    check("t3_pulses", rd_pulses - p0, 16);
    check("t3_words", exp_word, 16);

    // slow SRAM, ry four cycles late
    ry_delay = 4;
    run_pass(113, "t4", 0);
    ry_delay = 0;
    check("t4_err", int'(err), 0);
    check("t4_words", exp_word, 16);

    // timeout at address 2
    never_addr = 2;
    p0 = rd_pulses;
    run_pass(23, "t5", 0);
    check("t5_err", int'(err), 1);
    check("t5_words", exp_word, 2);
    check("t5_pulses", rd_pulses - p0, 3);
    @(posedge clk);
    #1;
    check("t5_idle", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_sticky", int'(err), 1);
    never_addr = -1;

    // stray start/ry during a stalled HOLD
    stall_word = 5;
    stall_len = 4;
    inj_en = 1;
    p0 = rd_pulses;
    run_pass(53, "t6", 0);
    inj_en = 0;
    stall_len = 0;
    check("t6_pulses", rd_pulses - p0, 16);
    check("t6_words", exp_word, 16);

    // reset in the middle of HOLD
    ready_default = 0;
    @(posedge clk);
    #1;
    start_m = 1'b1;
    @(posedge clk);
    #1;
    start_m = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t1_hold", int'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("t1_rn", int'(read_n), 1);
    check("t1_addr", int'(r_addr), 0);
    check("t1_valid", int'(out_valid), 0);
    check("t1_data", int'(out_data), 0);
    check("t1_last", int'(out_last), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_done", int'(done), 0);
    check("t1_err", int'(err), 0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_nodone", int'(done), 0);
    rst = 1'b1;
    ready_default = 1;
    p0 = rd_pulses;
    run_pass(49, "t1r", 0);
    check("t1r_pulses", rd_pulses - p0, 16);
    check("t1r_words", exp_word, 16);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
